// File: rtl/adc_spi_reader_if.sv
// Sample bus between the ADC reader and its consumers, plus the ADC serial pins.
//   adc_cs_n   : ADC chip select, active low (reader -> ADC)
//   adc_sclk   : ADC serial clock, idles high (reader -> ADC)
//   adc_miso   : ADC serial data (ADC -> reader)
//   sample     : last converted 12-bit value (reader -> filter chain)
//   data_valid : one-cycle strobe, new sample available (reader -> filter chain)
//   frame_err  : leading-zero bits of the last frame were not all zero
// master = the reader, slave = ADC + downstream consumer side.
interface adc_spi_reader_if;
    localparam int unsigned SAMPLE_W = 12;

    logic                adc_cs_n;
    logic                adc_sclk;
    logic                adc_miso;
    logic [SAMPLE_W-1:0] sample;
    logic                data_valid;
    logic                frame_err;

    modport master (
        output adc_cs_n, adc_sclk, sample, data_valid, frame_err,
        input  adc_miso
    );

    modport slave (
        input  adc_cs_n, adc_sclk, sample, data_valid, frame_err,
        output adc_miso
    );
endinterface

// File: rtl/adc_spi_reader.sv
// Paced acquisition front end for a 12-bit serial ADC (16-SCLK frame, 4 leading
// zeros then 12 data bits MSB first). Starts a conversion every SAMPLE_PERIOD
// clk cycles while enable is high and publishes each result with a one-cycle
// data_valid strobe one cycle after sample settles.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset; aborts any frame in flight
//   enable : run conversions; dropping it lets the current frame finish
//   bus    : master side of adc_spi_reader_if (SPI pins + sample bus)
module adc_spi_reader #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    adc_spi_reader_if.master bus
);
    localparam int unsigned HCNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PCNT_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned BCNT_W   = 4;
    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned SAMPLE_W = 12;

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT, CS_HOLD, PUB, STROBE
    } state_e;

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                ferr_q, ferr_d;
    logic                dv_q, dv_d;
    logic                tick_c;
    logic                half_done_c;

    assign tick_c      = enable && (pcnt_q == '0);
    assign half_done_c = (hcnt_q == HCNT_W'(CLK_DIV - 1));

    // Conversion pacing: free-runs only while enabled, so re-enabling starts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (!enable || (pcnt_q == PCNT_W'(SAMPLE_PERIOD - 1))) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The 16th SCLK rise is the low->high turn with bcnt at 15.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (tick_c) state_d = CS_SETUP;
            CS_SETUP: if (half_done_c) state_d = SHIFT;
            SHIFT:    if (half_done_c && !sclk_q && (bcnt_q == BCNT_W'(FRAME_W - 1))) state_d = CS_HOLD;
            CS_HOLD:  if (half_done_c) state_d = PUB;
            PUB:      state_d = STROBE;
            STROBE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        sample_d = sample_q;
        ferr_d   = ferr_q;
        dv_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick_c) begin
                    cs_n_d = 1'b0;
                    sclk_d = 1'b1;
                    hcnt_d = '0;
                    bcnt_d = '0;
                end
            end
            CS_SETUP: begin
                if (half_done_c) begin
                    hcnt_d = '0;
                    sclk_d = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            SHIFT: begin
                if (half_done_c) begin
                    hcnt_d = '0;
                    sclk_d = ~sclk_q;
                    // Capture on the edge that raises SCLK; the ADC updates on the fall.
                    if (!sclk_q) begin
                        shift_d = {shift_q[FRAME_W-2:0], bus.adc_miso};
                        bcnt_d  = bcnt_q + BCNT_W'(1);
                    end
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            CS_HOLD: begin
                if (half_done_c) begin
                    hcnt_d = '0;
                    cs_n_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            PUB: begin
                sample_d = shift_q[SAMPLE_W-1:0];
                ferr_d   = |shift_q[FRAME_W-1:SAMPLE_W];
            end
            STROBE: begin
                dv_d = 1'b1;
            end
            default: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            hcnt_q   <= '0;
            bcnt_q   <= '0;
            shift_q  <= '0;
            sample_q <= '0;
            ferr_q   <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            ferr_q   <= ferr_d;
            dv_q     <= dv_d;
        end
    end

    assign bus.adc_cs_n   = cs_n_q;
    assign bus.adc_sclk   = sclk_q;
    assign bus.sample     = sample_q;
    assign bus.frame_err  = ferr_q;
    assign bus.data_valid = dv_q;

endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

Acquisition front end that drives a 12-bit serial ADC (16-SCLK frame: 4 leading zeros, then 12 data bits, MSB first), paces conversions at a fixed sample rate, and publishes each result as a 12-bit `sample` with a single-cycle `data_valid` strobe. It is the producer side of the sample/`data_valid` interface consumed by the filtering chain (median filter and successors), which clocks on the rising edge of `data_valid`. `sample` must therefore be stable before `data_valid` rises and held stable between strobes.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCLK half-period; legal range ≥1.
- `SAMPLE_PERIOD`, default 1000: clk cycles between conversion starts; must be ≥ 34*CLK_DIV+2.
- `clk` input 1: single system clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: when high, conversions run every SAMPLE_PERIOD cycles.
- `adc_miso` input 1: ADC serial data, sampled directly with no synchronizer.
- `adc_cs_n` output 1: ADC chip select, active-low, registered.
- `adc_sclk` output 1: ADC serial clock, idles high, registered.
- `sample` output 12: last converted value, unsigned.
- `data_valid` output 1: one-clk-cycle high strobe, registered, glitch-free.
- `frame_err` output 1: high when any of the 4 leading bits of the last frame was 1; updates with `sample`.

## Operation
- Reset (async, on `rst_n` low): state IDLE; `adc_cs_n`=1, `adc_sclk`=1, `sample`=0, `data_valid`=0, `frame_err`=0; period counter, half-period counter, bit counter, and shift register are all 0.
- Period counter: held at 0 while `enable`=0. While `enable`=1 it counts 0..SAMPLE_PERIOD-1 and wraps. A start tick occurs when the counter is 0 and `enable`=1. A tick outside IDLE is ignored.
- States:
  - IDLE → CS_SETUP on a start tick.
  - CS_SETUP: `adc_cs_n`=0, `adc_sclk`=1, for CLK_DIV cycles, then → SHIFT.
  - SHIFT: 16 SCLK periods, each CLK_DIV cycles low followed by CLK_DIV cycles high. On the clk edge that drives `adc_sclk` 0→1, `adc_miso` is shifted into the shift register LSB. After the 16th rising edge, → CS_HOLD.
  - CS_HOLD: `adc_sclk`=1 for CLK_DIV cycles, then `adc_cs_n`→1 and → PUB.
  - PUB (1 cycle): `sample`<=shift[11:0], `frame_err`<=|shift[15:12], then → STROBE.
  - STROBE (1 cycle): `data_valid`=1, then → IDLE.
- Deasserting `enable` mid-conversion does not abort: the frame completes and publishes, then the block stays in IDLE.
- Re-asserting `enable` in IDLE starts a conversion on the first cycle it is high.
- Asserting `rst_n` mid-conversion aborts immediately: `adc_cs_n` and `adc_sclk` go high, and no strobe is issued.
- `sample` and `frame_err` change only in PUB. `frame_err` does not block publication.

## Timing
- Let E0 be the clk edge at which `adc_cs_n` falls (the start tick edge).
- First `adc_sclk` fall occurs at E0+CLK_DIV.
- Rising edges occur at E0+(2k+2)*CLK_DIV for k=0..15; the bit captured at rising edge k is frame bit 15-k.
- `adc_cs_n` rises at E0+33*CLK_DIV.
- `sample` updates at E0+33*CLK_DIV+1.
- `data_valid` is high for exactly the cycle following E0+33*CLK_DIV+2. With defaults, that cycle is at E0+134, one cycle after `sample` changes.
- Consecutive E0 edges are exactly SAMPLE_PERIOD cycles apart while `enable` stays high.
- `data_valid` strobes are therefore also SAMPLE_PERIOD apart. `sample` holds for SAMPLE_PERIOD-1 cycles after each strobe.
- SCLK frequency = f_clk/(2*CLK_DIV); with defaults at 100 MHz, 12.5 MHz.

## Test plan
- Reset: hold `rst_n`=0 with `enable`=1 → all outputs at their reset values. Release → `adc_cs_n` falls on the first clk edge.
- Single frame: ADC model returns 0x0ABC, CLK_DIV=4 → `sample`=0xABC at E0+133, one `data_valid` pulse at E0+134, `frame_err`=0, and exactly 16 SCLK rising edges.
- Frame error: model returns 0xF123 → `sample`=0x123, `frame_err`=1, `data_valid` pulses normally.
- Streaming: SAMPLE_PERIOD=200, model values 0x001, 0xFFF, 0x800 → `adc_cs_n` falls at E0, E0+200, E0+400. The strobed values arrive in order, and a downstream edge-clocked register captures each one correctly.
- Enable drop: deassert `enable` during SHIFT → the frame completes and strobes once, with no further `adc_cs_n` fall. Re-assert → `adc_cs_n` falls on the next edge.
- Reset mid-shift: pulse `rst_n` low at bit 7 → `adc_cs_n`=1 and `adc_sclk`=1 immediately, with no `data_valid` and `sample`=0. After release, a normal frame follows.
